// File: rtl/fifo_reader.sv
// Drains a registered-output FIFO into a valid/ready stream through a 3-entry skid buffer,
// counting completed downstream transfers.
module fifo_reader #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_rd_en,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [CNT_W-1:0] xfer_count
);

  localparam int unsigned Depth = 3;

  logic [WIDTH-1:0] buf_q [Depth];
  logic [WIDTH-1:0] buf_d [Depth];
  logic [1:0]       occ_q, occ_d;
  logic             in_flight_q;
  logic             armed_q;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       outstanding;
  logic             pop;

  // Reserve a slot for every word already requested so a capture can never overflow.
  assign outstanding = {1'b0, occ_q} + {2'b00, in_flight_q};
  assign fifo_rd_en  = armed_q & en & ~fifo_empty & (outstanding < 3'(Depth));
  assign pop         = valid_q & m_ready;

  assign m_valid    = valid_q;
  assign m_data     = buf_q[0];
  assign xfer_count = cnt_q;

  always_comb begin
    buf_d = buf_q;
    occ_d = occ_q;
    cnt_d = cnt_q;
    if (pop) begin
      for (int i = 0; i < Depth - 1; i++) begin
        buf_d[i] = buf_q[i+1];
      end
      occ_d = occ_q - 2'd1;
      cnt_d = cnt_q + CNT_W'(1);
    end
    // The captured word lands behind whatever survives this cycle's pop.
    if (in_flight_q) begin
      for (int i = 0; i < Depth; i++) begin
        if (occ_d == 2'(i)) begin
          buf_d[i] = fifo_data;
        end
      end
      occ_d = occ_d + 2'd1;
    end
    valid_d = (occ_d != 2'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) begin
        buf_q[i] <= '0;
      end
      occ_q       <= 2'd0;
      in_flight_q <= 1'b0;
      armed_q     <= 1'b0;
      valid_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      buf_q       <= buf_d;
      occ_q       <= occ_d;
      in_flight_q <= fifo_rd_en;
      armed_q     <= 1'b1;
      valid_q     <= valid_d;
      cnt_q       <= cnt_d;
    end
  end

`ifndef SYNTHESIS
  a_no_read_when_empty: assert property (@(posedge clk) disable iff (rst)
    fifo_rd_en |-> !fifo_empty);
  a_hold_when_stalled: assert property (@(posedge clk) disable iff (rst)
    (m_valid && !m_ready) |=> (m_valid && $stable(m_data)));
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    in_flight_q |-> (occ_q != 2'd3 || pop));
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader: a queue-based FIFO/stream model checked every cycle,
// plus literal expectations per scenario.
module tb_fifo_reader;

  localparam int unsigned Width = 8;
  localparam int unsigned CntW  = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             fifo_empty;
  logic [Width-1:0] fifo_data = '0;
  logic             fifo_rd_en;
  logic             m_valid;
  logic             m_ready;
  logic [Width-1:0] m_data;
  logic [CntW-1:0]  xfer_count;

  fifo_reader #(
    .WIDTH (Width),
    .CNT_W (CntW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .xfer_count (xfer_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Source FIFO: registered read data, empty flag follows the pointers.
  logic [Width-1:0] mem [64];
  int wr_cnt = 0;
  int rd_ptr = 0;
  assign fifo_empty = (rd_ptr == wr_cnt);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_data <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  task automatic load(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      mem[wr_cnt] = Width'(base + i);
      wr_cnt++;
    end
  endtask

  // Model: every requested word becomes visible two edges after its request is seen.
  int cyc = 0;
  bit armed_m = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) armed_m <= !rst;

  logic [Width-1:0] exp_q[$];
  int               arr_q[$];
  logic [Width-1:0] got[$];
  int               got_cyc[$];
  int               model_cnt = 0;
  int               pulses = 0;
  int               first_rd = -1;
  int               first_valid = -1;

  always @(negedge clk) begin
    logic avail;
    logic exp_rd;
    if (rst) begin
      exp_q.delete();
      arr_q.delete();
      model_cnt = 0;
      check("rst_rd_en", 32'(fifo_rd_en), 0);
      check("rst_m_valid", 32'(m_valid), 0);
      check("rst_m_data", 32'(m_data), 0);
      check("rst_xfer_count", 32'(xfer_count), 0);
    end else begin
      avail = (arr_q.size() > 0) && (arr_q[0] <= cyc);
      check("m_valid", 32'(m_valid), 32'(avail));
      if (avail) check("m_data", 32'(m_data), 32'(exp_q[0]));
      check("xfer_count", 32'(xfer_count), 32'(model_cnt % (1 << CntW)));
      exp_rd = armed_m && en && !fifo_empty && (exp_q.size() < 3);
      check("fifo_rd_en", 32'(fifo_rd_en), 32'(exp_rd));
      if (fifo_rd_en) begin
        pulses++;
        if (first_rd < 0) first_rd = cyc;
        exp_q.push_back(mem[rd_ptr]);
        arr_q.push_back(cyc + 2);
      end
      if (m_valid && first_valid < 0) first_valid = cyc;
      if (avail && m_ready) begin
        got.push_back(m_data);
        got_cyc.push_back(cyc);
        void'(exp_q.pop_front());
        void'(arr_q.pop_front());
        model_cnt++;
      end
    end
  end

  task automatic wait_got(input int n, input int limit, input string name);
    int k = 0;
    while (got.size() < n && k < limit) begin
      @(posedge clk);
      k++;
    end
    #1;
    check(name, 32'(got.size() >= n), 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic check_seq(input string name, input int n, input int base);
    check({name, "_len"}, 32'(got.size()), 32'(n));
    for (int i = 0; i < n && i < got.size(); i++) begin
      check(name, 32'(got[i]), 32'(base + i));
    end
  endtask

  initial begin
    int rel;
    int k;
    rst = 1'b1;
    en = 1'b0;
    m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", 32'(m_valid), 0);
    check("reset_xfer", 32'(xfer_count), 0);
    check("reset_rd_en", 32'(fifo_rd_en), 0);

    // Streaming at full rate; inputs are live before reset releases.
    load(8, 1);
    en = 1'b1;
    m_ready = 1'b1;
    got.delete();
    got_cyc.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    rel = cyc;
    wait_got(8, 50, "s1_timeout");
    check_seq("s1_data", 8, 1);
    if (got_cyc.size() == 8) check("s1_back_to_back", 32'(got_cyc[7] - got_cyc[0]), 7);
    check("s1_first_rd", 32'(first_rd), 32'(rel + 1));
    check("s1_latency", 32'(first_valid - first_rd), 2);
    check("s1_xfer", 32'(xfer_count), 8);

    // Downstream stalled: three requests fill the buffer, head held.
    en = 1'b0;
    do_reset();
    got.delete();
    pulses = 0;
    load(8, 1);
    m_ready = 1'b0;
    en = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("s2_pulses", 32'(pulses), 3);
    check("s2_valid_held", 32'(m_valid), 1);
    check("s2_data_held", 32'(m_data), 1);
    m_ready = 1'b1;
    wait_got(8, 50, "s2_timeout");
    check_seq("s2_data", 8, 1);
    check("s2_xfer", 32'(xfer_count), 8);

    // Alternating ready.
    en = 1'b0;
    do_reset();
    got.delete();
    load(8, 1);
    en = 1'b1;
    k = 0;
    while (got.size() < 8 && k < 60) begin
      m_ready = (k % 2 == 0);
      @(posedge clk);
      #1;
      k++;
    end
    check_seq("s3_data", 8, 1);
    check("s3_xfer", 32'(xfer_count), 8);

    // Enable drops after two reads.
    en = 1'b0;
    do_reset();
    got.delete();
    pulses = 0;
    load(8, 1);
    m_ready = 1'b1;
    en = 1'b1;
    k = 0;
    while (pulses < 2 && k < 20) begin
      @(posedge clk);
      k++;
    end
    #1 en = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("s4_pulses", 32'(pulses), 2);
    check_seq("s4_data", 2, 1);
    check("s4_fifo_nonempty", 32'(fifo_empty), 0);
    check("s4_xfer", 32'(xfer_count), 2);

    // Reset with two buffered words and one in flight.
    got.delete();
    m_ready = 1'b0;
    en = 1'b1;
    k = 0;
    while (pulses < 5 && k < 20) begin
      @(posedge clk);
      k++;
    end
    #1;
    check("s5_pre_valid", 32'(m_valid), 1);
    check("s5_pre_data", 32'(m_data), 3);
    rst = 1'b1;
    #1;
    check("s5_rst_valid", 32'(m_valid), 0);
    check("s5_rst_xfer", 32'(xfer_count), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    m_ready = 1'b1;
    got.delete();
    wait_got(3, 50, "s5_timeout");
    repeat (5) @(posedge clk);
    #1;
    check_seq("s5_data", 3, 6);
    check("s5_fifo_empty", 32'(fifo_empty), 1);
    check("s5_xfer", 32'(xfer_count), 3);

    // Counter wrap with a 4-bit count.
    en = 1'b0;
    do_reset();
    got.delete();
    load(17, 32);
    m_ready = 1'b1;
    en = 1'b1;
    wait_got(15, 100, "s6_timeout");
    check("s6_xfer_15", 32'(xfer_count), 15);
    @(posedge clk);
    #1 check("s6_xfer_16", 32'(xfer_count), 0);
    @(posedge clk);
    #1 check("s6_xfer_17", 32'(xfer_count), 1);
    wait_got(17, 20, "s6_drain");
    check_seq("s6_data", 17, 32);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
